// File: rtl/walk_on_req_n.sv
// Purpose : one-hot LED walker (bounce or one-way sweeps) started by a synchronised rising edge of i_req.
// Latency : o_led[0] lights SYNC_STAGES+2 edges after the first edge that samples i_req high.
// Backpres: none; one start may queue behind an active walk, further starts are dropped.
//
// Ports:
//   i_clk, i_rst     clock; asynchronous active-high reset
//   i_req            asynchronous request, rising edge starts a walk
//   i_mode           0 = bounce, 1 = one-way (sampled at walk start)
//   i_repeats        number of extra sweeps (sampled at walk start)
//   i_abort          synchronous abort, wins over everything else
//   o_led            registered one-hot light, zero when idle
//   o_busy           registered, high while walking
//   o_done           registered one-cycle pulse on normal completion
module walk_on_req_n #(
    parameter int N_LEDS       = 4,
    parameter int DIV_WIDTH    = 2,
    parameter int REPEAT_WIDTH = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req,
    input  logic                    i_mode,
    input  logic [REPEAT_WIDTH-1:0] i_repeats,
    input  logic                    i_abort,
    output logic [N_LEDS-1:0]       o_led,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int KW = $clog2(2 * N_LEDS);

    // Last step index of a sweep for each mode.
    localparam logic [KW-1:0] K_LAST_ONEWAY = KW'(N_LEDS - 1);
    localparam logic [KW-1:0] K_LAST_BOUNCE = KW'(2 * N_LEDS - 3);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WALK = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Request synchroniser and edge detect.
    // Stages and the "last" flop reset to 1 so a request already high
    // when reset releases is not mistaken for a new rising edge.
    // r_start_q is a retiming stage between the edge detector and the FSM.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_start;
    logic                   r_start_q;
    logic                   w_sync_out;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync    <= '1;
            r_last    <= 1'b1;
            r_start   <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_req};
            r_last    <= w_sync_out;
            r_start   <= w_sync_out & ~r_last;
            r_start_q <= r_start;
        end
    end

    // ------------------------------------------------------------------
    // Walk state
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [KW-1:0]           r_k;
    logic [DIV_WIDTH-1:0]    r_div;
    logic [REPEAT_WIDTH-1:0] r_sweeps;
    logic                    r_mode;
    logic                    r_pending;

    state_t                  w_state_nxt;
    logic [KW-1:0]           w_k_nxt;
    logic [DIV_WIDTH-1:0]    w_div_nxt;
    logic [REPEAT_WIDTH-1:0] w_sweeps_nxt;
    logic                    w_mode_nxt;
    logic                    w_pending_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic [N_LEDS-1:0]       w_led_nxt;
    logic                    w_stb;
    logic [KW-1:0]           w_k_last;

    assign w_stb    = (r_div == '1);
    assign w_k_last = r_mode ? K_LAST_ONEWAY : K_LAST_BOUNCE;

    // Step index to LED: rising half is k itself, falling half mirrors back.
    function automatic logic [N_LEDS-1:0] led_of_k(input logic [KW-1:0] k);
        logic [KW-1:0] pos;
        if (k < KW'(N_LEDS)) begin
            pos = k;
        end else begin
            pos = KW'(2 * N_LEDS - 2) - k;
        end
        return {{(N_LEDS-1){1'b0}}, 1'b1} << pos;
    endfunction

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_div_nxt     = r_div + 1'b1;   // free-running, wraps naturally
        w_sweeps_nxt  = r_sweeps;
        w_mode_nxt    = r_mode;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // An abort on the same edge swallows the start.
                if (r_start_q && !i_abort) begin
                    w_state_nxt   = S_WALK;
                    w_k_nxt       = '0;
                    w_div_nxt     = '0;
                    w_mode_nxt    = i_mode;
                    w_sweeps_nxt  = i_repeats;
                    w_pending_nxt = 1'b0;
                end
            end
            S_WALK: begin
                if (i_abort) begin
                    w_state_nxt   = S_IDLE;
                    w_k_nxt       = '0;
                    w_pending_nxt = 1'b0;
                end else begin
                    if (r_start_q) begin
                        w_pending_nxt = 1'b1;
                    end
                    if (w_stb) begin
                        if (r_k != w_k_last) begin
                            w_k_nxt = r_k + 1'b1;
                        end else if (r_sweeps != '0) begin
                            w_sweeps_nxt = r_sweeps - 1'b1;
                            w_k_nxt      = '0;
                        end else begin
                            w_done_nxt = 1'b1;
                            w_k_nxt    = '0;
                            // A start landing on the completion edge is treated
                            // like a queued one so it is not lost.
                            if (r_pending || r_start_q) begin
                                w_div_nxt     = '0;
                                w_mode_nxt    = i_mode;
                                w_sweeps_nxt  = i_repeats;
                                w_pending_nxt = 1'b0;
                            end else begin
                                w_state_nxt   = S_IDLE;
                                w_pending_nxt = 1'b0;
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_WALK);
        w_led_nxt  = w_busy_nxt ? led_of_k(w_k_nxt) : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_div     <= '0;
            r_sweeps  <= '0;
            r_mode    <= 1'b0;
            r_pending <= 1'b0;
            o_led     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_div     <= w_div_nxt;
            r_sweeps  <= w_sweeps_nxt;
            r_mode    <= w_mode_nxt;
            r_pending <= w_pending_nxt;
            o_led     <= w_led_nxt;
            o_busy    <= w_busy_nxt;
            o_done    <= w_done_nxt;
        end
    end

endmodule

// File: doc/walk_on_req_n.md
Name: walk_on_req_n

Overview:
Parametrised LED walker triggered by an asynchronous request. On each synchronised rising edge of the request it sweeps a one-hot light across N_LEDS outputs, either one-way or bouncing, for a programmable number of sweeps. Adds a one-deep request queue, a synchronous abort, and busy/done status. It drives board LEDs directly and is also reused as a visible activity indicator.

Parameters:
N_LEDS, 4, number of LED outputs; legal range >= 2
DIV_WIDTH, 2, step divider width; each position is held for 2^DIV_WIDTH cycles
REPEAT_WIDTH, 2, width of i_repeats
SYNC_STAGES, 2, flop count in the i_req synchroniser; legal range >= 2

Ports:
i_clk  in  1  single clock
i_rst  in  1  reset, asynchronous, active-high
i_req  in  1  asynchronous walk request; rising edge starts a walk
i_mode  in  1  0 = bounce, 1 = one-way; sampled at walk start
i_repeats  in  REPEAT_WIDTH  sweeps = i_repeats + 1; sampled at walk start
i_abort  in  1  synchronous abort, level sampled each edge
o_led  out  N_LEDS  registered; one-hot while busy, all-zero when idle
o_busy  out  1  registered; high while walking
o_done  out  1  registered one-cycle pulse on normal walk completion

Behaviour:
- Reset:
  - All synchroniser stages and the edge-detect "last" flop reset to 1, so a level held across reset never starts a walk. A real 0->1 transition is required.
  - Everything else resets to 0: o_led, o_busy, o_done, pending, state = IDLE.
  - Asserting reset mid-walk clears the outputs immediately (asynchronously).
- Start pulse: start = sync_out && !last, registered.
  - If i_req rises before edge E0, o_led = 1 becomes visible after edge E0 + SYNC_STAGES + 2.
- State machine: IDLE and WALK.
  - IDLE + start:
    - go to WALK
    - latch mode and repeats into sweeps_left
    - step index k = 0
    - divider cleared
    - o_led = 1 (bit 0), o_busy = 1
- Sweep length L:
  - bounce: L = 2*N_LEDS - 2
  - one-way: L = N_LEDS
- Position:
  - pos = k when k < N_LEDS, else 2*N_LEDS - 2 - k.
  - o_led = 1 << pos.
  - Bounce, N_LEDS = 4: positions 0,1,2,3,2,1.
- Divider and stepping:
  - Divider counts 0..2^DIV_WIDTH-1; stb is asserted when it equals its maximum.
  - Each position is held exactly 2^DIV_WIDTH cycles.
  - On stb with k < L-1: k += 1.
  - On stb with k = L-1 (end of sweep):
    - sweeps_left != 0: decrement, k = 0
    - sweeps_left = 0: complete the walk
- Completion:
  - Next cycle: o_led = 0, o_busy = 0, o_done = 1 for exactly one cycle, state = IDLE.
  - If pending = 1 instead: o_done = 1, o_busy stays 1, pending cleared, and the walk restarts at k = 0.
  - The restart re-samples i_mode/i_repeats and clears the divider. There is no idle gap.
- Queue: a start pulse while in WALK sets pending. Further starts while pending = 1 are dropped.
- Abort (i_abort = 1 at an edge):
  - In WALK: next cycle IDLE, o_led = 0, o_busy = 0, pending = 0, no o_done.
  - Abort has priority over stb, completion and start.
  - Abort and start in IDLE on the same edge: start is discarded.
- Width rules:
  - pos and k are sized with $clog2(2*N_LEDS).
  - sweeps_left is REPEAT_WIDTH bits; no wrap beyond 0.
  - The divider wraps freely.
- Busy time of a single walk: (i_repeats+1) * L * 2^DIV_WIDTH cycles.

Test Plan:
- Single bounce (N_LEDS=4, DIV_WIDTH=2, i_mode=0, i_repeats=0), one i_req pulse:
  - o_led = 1,2,4,8,4,2, each held 4 cycles.
  - o_busy high for 24 cycles.
  - One o_done pulse in the first cycle with o_led = 0.
- One-way with repeat (i_mode=1, i_repeats=1):
  - o_led = 1,2,4,8,1,2,4,8.
  - 32 busy cycles, one o_done.
- Queued request: second i_req edge at cycle 10 of a bounce walk:
  - o_busy continuously high for 48 cycles.
  - Two o_done pulses, at cycle 24 and cycle 48 of the burst.
  - A third edge during the same walk is dropped.
- Abort: i_abort high at cycle 9 of a walk:
  - Next cycle o_led = 0, o_busy = 0, no o_done.
  - A queued request is discarded.
  - Abort coincident with start in IDLE: nothing starts.
- Reset:
  - i_rst mid-walk: o_led = 0 immediately.
  - i_req held high through reset deassert: no walk.
  - i_req then toggled low->high: walk starts; o_led = 1 after SYNC_STAGES+2 edges.
- Boundary N_LEDS=2, bounce: o_led = 1,2 per sweep (L=2).
- Boundary N_LEDS=5, one-way: o_led = 1,2,4,8,16.
- i_repeats at its maximum (3 with REPEAT_WIDTH=2): exactly 4 sweeps.
